// File: rtl/mem_write_packer.sv
// mem_write_packer: coalesces flat byte writes into masked word writes
// for the DIM_X x DIM_Y word memory, dropping and counting OOB bytes.
module mem_write_packer #(
  parameter int DIM_X   = 3,
  parameter int DIM_Y   = 3,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IN_valid,
  input  logic [7:0]       IN_addr,
  input  logic [7:0]       IN_data,
  input  logic             IN_flush,
  output logic [3:0]       OUT_waddr_x,
  output logic [3:0]       OUT_waddr_y,
  output logic [31:0]      OUT_wdata,
  output logic [3:0]       OUT_wmask,
  output logic             OUT_pending,
  output logic [CNT_W-1:0] OUT_oob_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] NW = 7'(DIM_X * DIM_Y);
  localparam logic [5:0] LDY = 6'(DIM_Y);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_PART  = 1'b1
  } state_t;

  state_t           r_state, w_state_nx;
  logic [5:0]       r_widx, w_widx_nx;
  logic [31:0]      r_data, w_data_nx;
  logic [3:0]       r_mask, w_mask_nx;
  logic [TW-1:0]    r_timer, w_timer_nx;
  logic [CNT_W-1:0] r_oob;
  logic [3:0]       r_ox, r_oy, r_om;
  logic [31:0]      r_owd;

  logic [5:0]  w_widx;
  logic [1:0]  w_lane;
  logic        w_inb, w_acc, w_oob, w_same, w_tmo;
  logic [3:0]  w_lbit, w_mmask;
  logic [31:0] w_lword, w_lmsk, w_mdata;
  logic        w_emit;
  logic [5:0]  w_ewidx;
  logic [31:0] w_ewd;
  logic [3:0]  w_em;

  assign w_widx  = IN_addr[7:2];
  assign w_lane  = IN_addr[1:0];
  assign w_inb   = {1'b0, w_widx} < NW;
  assign w_acc   = IN_valid & w_inb;
  assign w_oob   = IN_valid & ~w_inb;
  assign w_same  = (r_state == S_PART) && (r_widx == w_widx);
  assign w_tmo   = (r_timer == TLAST);
  assign w_lbit  = 4'b0001 << w_lane;
  assign w_lword = 32'(IN_data) << {w_lane, 3'b000};
  assign w_lmsk  = 32'h0000_00FF << {w_lane, 3'b000};
  assign w_mdata = (r_data & ~w_lmsk) | w_lword;
  assign w_mmask = r_mask | w_lbit;

  // state, buffer, timer and drop counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_widx  <= '0;
      r_data  <= '0;
      r_mask  <= '0;
      r_timer <= '0;
      r_oob   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_widx  <= w_widx_nx;
      r_data  <= w_data_nx;
      r_mask  <= w_mask_nx;
      r_timer <= w_timer_nx;
      if (w_oob && (r_oob != '1))
        r_oob <= r_oob + CNT_W'(1);
    end
  end

  // next buffer contents: load, merge, flush and idle timeout
  always_comb begin
    w_state_nx = r_state;
    w_widx_nx  = r_widx;
    w_data_nx  = r_data;
    w_mask_nx  = r_mask;
    w_timer_nx = r_timer;
    unique case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_widx_nx  = w_widx;
          w_data_nx  = w_lword;
          w_mask_nx  = w_lbit;
          w_timer_nx = '0;
          w_state_nx = IN_flush ? S_EMPTY : S_PART;
        end
      end
      S_PART: begin
        if (w_acc && w_same) begin
          w_data_nx  = w_mdata;
          w_mask_nx  = w_mmask;
          w_timer_nx = '0;
          if (w_mmask == 4'hF || IN_flush)
            w_state_nx = S_EMPTY;
        end else if (w_acc) begin
          w_widx_nx  = w_widx;
          w_data_nx  = w_lword;
          w_mask_nx  = w_lbit;
          w_timer_nx = '0;
        end else if (IN_flush || w_tmo) begin
          w_state_nx = S_EMPTY;
          w_timer_nx = '0;
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      default: w_state_nx = S_EMPTY;
    endcase
  end

  // which word (if any) leaves the buffer this cycle
  always_comb begin
    w_emit  = 1'b0;
    w_ewidx = r_widx;
    w_ewd   = r_data;
    w_em    = r_mask;
    unique case (r_state)
      S_EMPTY: begin
        if (w_acc && IN_flush) begin
          w_emit  = 1'b1;
          w_ewidx = w_widx;
          w_ewd   = w_lword;
          w_em    = w_lbit;
        end
      end
      S_PART: begin
        if (w_acc && w_same) begin
          if (w_mmask == 4'hF || IN_flush) begin
            w_emit = 1'b1;
            w_ewd  = w_mdata;
            w_em   = w_mmask;
          end
        end else if (w_acc || IN_flush || w_tmo) begin
          w_emit = 1'b1;
        end
      end
      default: w_emit = 1'b0;
    endcase
  end

  // registered write port: one-cycle mask pulse, address/data hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ox  <= '0;
      r_oy  <= '0;
      r_owd <= '0;
      r_om  <= '0;
    end else if (w_emit) begin
      r_ox  <= 4'(w_ewidx / LDY);
      r_oy  <= 4'(w_ewidx % LDY);
      r_owd <= w_ewd;
      r_om  <= w_em;
    end else begin
      r_om  <= '0;
    end
  end

  assign OUT_waddr_x = r_ox;
  assign OUT_waddr_y = r_oy;
  assign OUT_wdata   = r_owd;
  assign OUT_wmask   = r_om;
  assign OUT_pending = (r_state == S_PART);
  assign OUT_oob_cnt = r_oob;

endmodule

// File: tb/tb_mem_write_packer.sv
// tb_mem_write_packer: table vectors, directed corner cases and a random
// stream checked against a lane-array reference model.
module tb_mem_write_packer;

  localparam int DX = 3;
  localparam int DY = 3;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IN_valid = 1'b0;
  logic [7:0]  IN_addr = '0;
  logic [7:0]  IN_data = '0;
  logic        IN_flush = 1'b0;
  logic [3:0]  OUT_waddr_x, OUT_waddr_y, OUT_wmask;
  logic [31:0] OUT_wdata;
  logic        OUT_pending;
  logic [7:0]  OUT_oob_cnt;

  always #5 clk = ~clk;

  mem_write_packer #(
    .DIM_X(DX), .DIM_Y(DY), .TIMEOUT(TO), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .IN_valid(IN_valid), .IN_addr(IN_addr),
    .IN_data(IN_data), .IN_flush(IN_flush),
    .OUT_waddr_x(OUT_waddr_x), .OUT_waddr_y(OUT_waddr_y),
    .OUT_wdata(OUT_wdata), .OUT_wmask(OUT_wmask),
    .OUT_pending(OUT_pending), .OUT_oob_cnt(OUT_oob_cnt)
  );

  int errors = 0;
  int checks = 0;

  bit         m_pend;
  int         m_w;
  logic [7:0] m_b [4];
  bit   [3:0] m_v;
  int         m_idle;
  int         m_oob;
  logic [3:0] m_x, m_y, m_m;
  logic [31:0] m_wd;

  typedef struct {
    bit          v;
    int          a;
    logic [7:0]  d;
    bit          f;
    logic [3:0]  em;
    logic [31:0] ewd;
    logic [3:0]  ex;
    logic [3:0]  ey;
    bit          ep;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic void m_emit();
    m_x  = 4'(m_w / DY);
    m_y  = 4'(m_w % DY);
    m_m  = m_v;
    m_wd = '0;
    for (int i = 0; i < 4; i++)
      if (m_v[i]) m_wd[i*8 +: 8] = m_b[i];
  endfunction

  task automatic m_step(input bit v, input int a, input logic [7:0] d,
                        input bit f, input bit r);
    int w, ln;
    bit emitted, acc;
    if (!r) begin
      m_pend = 0; m_v = 0; m_idle = 0; m_oob = 0;
      m_x = 0; m_y = 0; m_m = 0; m_wd = 0;
      return;
    end
    w = a / 4;
    ln = a % 4;
    emitted = 0;
    m_m = 0;
    acc = v && (w < DX * DY);
    if (v && !acc && m_oob < 255) m_oob++;
    if (acc) begin
      m_idle = 0;
      if (m_pend && w != m_w) begin
        m_emit();
        emitted = 1;
        m_v = 0;
        m_w = w;
      end else if (!m_pend) begin
        m_pend = 1;
        m_v = 0;
        m_w = w;
      end
      m_b[ln] = d;
      m_v[ln] = 1'b1;
      if (!emitted && (m_v == 4'hF || f)) begin
        m_emit();
        m_pend = 0;
      end
    end else if (m_pend) begin
      m_idle++;
      if (f || m_idle == TO) begin
        m_emit();
        m_pend = 0;
      end
    end
  endtask

  task automatic cyc(input bit v, input int a, input logic [7:0] d,
                     input bit f, input bit r);
    IN_valid = v;
    IN_addr  = 8'(a);
    IN_data  = d;
    IN_flush = f;
    rst_n    = r;
    m_step(v, a, d, f, r);
    @(posedge clk);
    #1;
    chk("mdl_mask", OUT_wmask, m_m);
    chk("mdl_wdata", OUT_wdata, m_wd);
    chk("mdl_x", OUT_waddr_x, m_x);
    chk("mdl_y", OUT_waddr_y, m_y);
    chk("mdl_pend", OUT_pending, m_pend);
    chk("mdl_oob", OUT_oob_cnt, m_oob);
  endtask

  initial begin
    int a, lastw;
    bit v, f, r;

    tv[0]  = '{1, 16, 8'h11, 0, 4'h0, 32'h0,        0, 0, 1};
    tv[1]  = '{1, 17, 8'h22, 0, 4'h0, 32'h0,        0, 0, 1};
    tv[2]  = '{1, 18, 8'h33, 0, 4'h0, 32'h0,        0, 0, 1};
    tv[3]  = '{1, 19, 8'h44, 0, 4'hF, 32'h44332211, 1, 1, 0};
    tv[4]  = '{0, 0,  8'h00, 0, 4'h0, 32'h44332211, 1, 1, 0};
    tv[5]  = '{1, 0,  8'hAA, 0, 4'h0, 32'h44332211, 1, 1, 1};
    tv[6]  = '{1, 5,  8'hBB, 0, 4'h1, 32'h000000AA, 0, 0, 1};
    tv[7]  = '{0, 0,  8'h00, 1, 4'h2, 32'h0000BB00, 0, 1, 0};
    tv[8]  = '{1, 8,  8'h01, 0, 4'h0, 32'h0000BB00, 0, 1, 1};
    tv[9]  = '{1, 9,  8'h02, 1, 4'h3, 32'h00000201, 0, 2, 0};
    tv[10] = '{0, 0,  8'h00, 0, 4'h0, 32'h00000201, 0, 2, 0};

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_mask", OUT_wmask, 0);
    chk("rst_wdata", OUT_wdata, 0);
    chk("rst_pend", OUT_pending, 0);
    chk("rst_oob", OUT_oob_cnt, 0);

    for (int i = 0; i < 11; i++) begin
      cyc(tv[i].v, tv[i].a, tv[i].d, tv[i].f, 1);
      chk($sformatf("tv%0d_mask", i), OUT_wmask, tv[i].em);
      chk($sformatf("tv%0d_wdata", i), OUT_wdata, tv[i].ewd);
      chk($sformatf("tv%0d_x", i), OUT_waddr_x, tv[i].ex);
      chk($sformatf("tv%0d_y", i), OUT_waddr_y, tv[i].ey);
      chk($sformatf("tv%0d_pend", i), OUT_pending, tv[i].ep);
    end

    cyc(1, 34, 8'h5A, 0, 1);
    for (int k = 2; k <= 9; k++) begin
      cyc(0, 0, 0, 0, 1);
      if (k < 9) begin
        chk($sformatf("tmo_early%0d", k), OUT_wmask, 0);
      end else begin
        chk("tmo_mask", OUT_wmask, 4'h4);
        chk("tmo_wdata", OUT_wdata, 32'h005A0000);
        chk("tmo_x", OUT_waddr_x, 2);
        chk("tmo_y", OUT_waddr_y, 2);
      end
    end

    cyc(1, 0, 8'h77, 0, 1);
    cyc(1, 36, 8'h01, 0, 1);
    cyc(1, 255, 8'h02, 0, 1);
    chk("oob_cnt2", OUT_oob_cnt, 2);
    chk("oob_mask", OUT_wmask, 0);
    chk("oob_pend", OUT_pending, 1);
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 300; i++)
      cyc(1, int'($urandom_range(36, 255)), 8'(i), 0, 1);
    chk("oob_sat", OUT_oob_cnt, 255);

    cyc(1, 12, 8'h3C, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst2_pend", OUT_pending, 0);
    chk("rst2_mask", OUT_wmask, 0);
    chk("rst2_wdata", OUT_wdata, 0);
    chk("rst2_x", OUT_waddr_x, 0);
    chk("rst2_oob", OUT_oob_cnt, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("rst2_nowr", OUT_wmask, 0);
    end

    lastw = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      if (((i / 64) % 4) == 3) v = ($urandom_range(0, 15) == 0);
      else v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0)
        a = int'($urandom_range(36, 255));
      else if ($urandom_range(0, 1) == 0)
        a = lastw * 4 + int'($urandom_range(0, 3));
      else
        a = int'($urandom_range(0, 35));
      if (a < 36) lastw = a / 4;
      f = ($urandom_range(0, 15) == 0);
      if (!m_pend && v && a < 36) f = 0;
      cyc(v, a, 8'($urandom), f, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
